// File: rtl/fir_mac_array_pkg.sv
// Shared definitions for the FIR MAC array: datapath widths and FSM state encoding.
// ACC_WIDTH must stay equal to the downstream sum stage's IN_WIDTH.
package fir_mac_array_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int COEFF_WIDTH   = 6;
    localparam int TAPS_PER_LANE = 8;
    localparam int NUM_LANES     = 4;
    localparam int NUM_TAPS      = NUM_LANES * TAPS_PER_LANE;
    localparam int ACC_WIDTH     = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS_PER_LANE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_SUM  = 2'd2
    } fir_state_e;

endpackage

// File: rtl/fir_mac_lane.sv
// One MAC lane: a private slice of coefficients, a signed multiplier and a
// clearable accumulator that sums one product per enabled cycle.
module fir_mac_lane #(
    parameter int DATA_WIDTH    = 16,
    parameter int COEFF_WIDTH   = 6,
    parameter int TAPS_PER_LANE = 8,
    parameter int ACC_WIDTH     = 25,
    localparam int TAP_W        = $clog2(TAPS_PER_LANE)
) (
    input  logic                          i_clk,
    input  logic                          i_rsn,
    input  logic                          i_coeff_wr_en,
    input  logic [TAP_W-1:0]              i_coeff_idx,
    input  logic signed [COEFF_WIDTH-1:0] i_coeff_data,
    input  logic [TAP_W-1:0]              i_tap,
    input  logic signed [DATA_WIDTH-1:0]  i_sample,
    input  logic                          i_clr,
    input  logic                          i_acc_en,
    output logic signed [ACC_WIDTH-1:0]   o_acc
);

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

    logic signed [COEFF_WIDTH-1:0] r_coeff [TAPS_PER_LANE];
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic signed [PROD_W-1:0]      w_prod;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;

    assign w_prod     = r_coeff[i_tap] * i_sample;
    assign w_prod_ext = {{(ACC_WIDTH - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign o_acc      = r_acc;

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            for (int i = 0; i < TAPS_PER_LANE; i++) begin
                r_coeff[i] <= '0;
            end
        end else if (i_coeff_wr_en) begin
            r_coeff[i_coeff_idx] <= i_coeff_data;
        end
    end

    // Clear and accumulate never coincide: clear happens in IDLE, accumulate in MAC.
    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule

// File: rtl/fir_mac_array.sv
// FIR producer: 32-tap delay line, sequencing FSM and four 8-tap MAC lanes that
// hand full-precision partial sums to the summation stage with a one-cycle strobe.
module fir_mac_array
    import fir_mac_array_pkg::*;
#(
    parameter int DATA_WIDTH    = fir_mac_array_pkg::DATA_WIDTH,
    parameter int COEFF_WIDTH   = fir_mac_array_pkg::COEFF_WIDTH,
    parameter int TAPS_PER_LANE = fir_mac_array_pkg::TAPS_PER_LANE,
    localparam int ACC_WIDTH    = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS_PER_LANE)
) (
    input  logic                          iClk12M,
    input  logic                          iRsn,
    input  logic                          iEnSample600k,
    input  logic signed [DATA_WIDTH-1:0]  iFirIn,
    input  logic                          iCoeffWrEn,
    input  logic [4:0]                    iCoeffAddr,
    input  logic signed [COEFF_WIDTH-1:0] iCoeffData,
    output logic signed [ACC_WIDTH-1:0]   oMac1,
    output logic signed [ACC_WIDTH-1:0]   oMac2,
    output logic signed [ACC_WIDTH-1:0]   oMac3,
    output logic signed [ACC_WIDTH-1:0]   oMac4,
    output logic                          oEnSum,
    output logic                          oBusy,
    output logic                          oOverrun,
    output fir_state_e                    oDbgState
);

    localparam int LANES  = 4;
    localparam int TAPS   = LANES * TAPS_PER_LANE;
    localparam int TAP_W  = $clog2(TAPS_PER_LANE);
    localparam int LANE_W = $clog2(LANES);

    fir_state_e                  r_state;
    logic [TAP_W-1:0]            r_tap;
    logic signed [DATA_WIDTH-1:0] r_x [TAPS];
    logic                        r_en_sum;
    logic                        r_busy;
    logic                        r_overrun;

    logic                        w_accept;
    logic                        w_coeff_wr;
    logic signed [DATA_WIDTH-1:0] w_sample [LANES];
    logic signed [ACC_WIDTH-1:0]  w_acc [LANES];

    assign w_accept   = (r_state == ST_IDLE) && iEnSample600k;
    assign w_coeff_wr = (r_state == ST_IDLE) && iCoeffWrEn;

    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            r_state   <= ST_IDLE;
            r_tap     <= '0;
            r_en_sum  <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iEnSample600k) begin
                        r_x[0] <= iFirIn;
                        for (int i = 1; i < TAPS; i++) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_tap   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    // A strobe here is dropped: the delay line must not move mid-run.
                    if (iEnSample600k) begin
                        r_overrun <= 1'b1;
                    end
                    r_tap <= r_tap + TAP_W'(1);
                    if (r_tap == TAP_W'(TAPS_PER_LANE - 1)) begin
                        r_en_sum <= 1'b1;
                        r_state  <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    if (iEnSample600k) begin
                        r_overrun <= 1'b1;
                    end
                    r_en_sum <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_en_sum <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        // Lane k owns taps 8k..8k+7, so the upper address bits select the lane.
        assign w_sample[k] = r_x[{LANE_W'(k), r_tap}];

        fir_mac_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .COEFF_WIDTH  (COEFF_WIDTH),
            .TAPS_PER_LANE(TAPS_PER_LANE),
            .ACC_WIDTH    (ACC_WIDTH)
        ) u_lane (
            .i_clk        (iClk12M),
            .i_rsn        (iRsn),
            .i_coeff_wr_en(w_coeff_wr && (iCoeffAddr[4:TAP_W] == LANE_W'(k))),
            .i_coeff_idx  (iCoeffAddr[TAP_W-1:0]),
            .i_coeff_data (iCoeffData),
            .i_tap        (r_tap),
            .i_sample     (w_sample[k]),
            .i_clr        (w_accept),
            .i_acc_en     (r_state == ST_MAC),
            .o_acc        (w_acc[k])
        );
    end

    assign oMac1     = w_acc[0];
    assign oMac2     = w_acc[1];
    assign oMac3     = w_acc[2];
    assign oMac4     = w_acc[3];
    assign oEnSum    = r_en_sum;
    assign oBusy     = r_busy;
    assign oOverrun  = r_overrun;
    assign oDbgState = r_state;

endmodule
